// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_ctrl
// Description : Ping-pong frame sequencer wrapped around a streaming FFT core.
//               Collects handshaked samples into two frame banks, feeds each
//               complete frame to the core gap-free, and tags the core output
//               with bin index and start/end-of-frame markers.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int N        = 16,
    parameter int DW       = 34,
    parameter int CORE_LAT = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic [DW-1:0]        core_din,
    input  logic [DW-1:0]        core_dout,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_bin,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int              c_AW   = $clog2(N);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DW-1:0]     r_mem [2*N];
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [c_AW-1:0]   r_wr_cnt;
    logic [c_AW-1:0]   r_rd_cnt;
    logic [c_AW-1:0]   r_out_cnt;
    logic              r_out_run;
    logic              r_ready_en;
    logic [CORE_LAT-1:0] r_lat_pipe;

    logic              w_accept;
    logic              w_wr_done;
    logic              w_wr_bad;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;
    logic              w_issue_last;
    logic              w_first;

    // in_ready is held low through reset and rises one clock after release
    assign in_ready   = r_ready_en && !r_full[r_wr_bank];
    assign w_accept   = in_valid && in_ready;
    // A frame is good only when in_last coincides with the final slot
    assign w_wr_done  = w_accept && in_last && (r_wr_cnt == c_LAST);
    assign w_wr_bad   = w_accept && (in_last != (r_wr_cnt == c_LAST));
    assign w_full_set = w_wr_done ? (2'b01 << r_wr_bank) : 2'b00;
    assign busy       = (|r_full) || (r_state == S_ISSUE) || (|r_lat_pipe) || r_out_run;

    // Sample storage: two banks of N entries, addressed {bank, slot}
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= in_data;
        end
    end

    // Write-side bookkeeping, bank occupancy and malformed-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_full     <= 2'b00;
            frame_err  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            frame_err  <= w_wr_bad;
            r_full     <= (r_full | w_full_set) & ~w_full_clr;
            if (w_accept) begin
                if (in_last || (r_wr_cnt == c_LAST)) begin
                    r_wr_cnt <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
        end
    end

    // Issue FSM state register plus read pointer and registered core drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
            core_din  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_ISSUE) begin
                core_din <= r_mem[{r_rd_bank, r_rd_cnt}];
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_issue_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else begin
                core_din <= '0;
                r_rd_cnt <= '0;
            end
        end
    end

    // Next-state logic; chains straight into the other bank when it is ready
    always_comb begin
        w_state_nxt  = r_state;
        w_issue_last = 1'b0;
        w_full_clr   = 2'b00;
        w_first      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_first = (r_rd_cnt == '0);
                if (r_rd_cnt == c_LAST) begin
                    w_issue_last = 1'b1;
                    w_full_clr   = 2'b01 << r_rd_bank;
                    w_state_nxt  = r_full[~r_rd_bank] ? S_ISSUE : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latency pipe: the start flag lines the out counter up with bin 0 on core_dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_pipe <= '0;
            r_out_run  <= 1'b0;
            r_out_cnt  <= '0;
        end else begin
            r_lat_pipe <= {r_lat_pipe[CORE_LAT-2:0], w_first};
            if (r_lat_pipe[CORE_LAT-1]) begin
                r_out_run <= 1'b1;
                r_out_cnt <= '0;
            end else if (r_out_run) begin
                r_out_cnt <= r_out_cnt + 1'b1;
                if (r_out_cnt == c_LAST) begin
                    r_out_run <= 1'b0;
                end
            end
        end
    end

    // Registered output stage: capture core_dout with its bin tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bin   <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= r_out_run;
            out_data  <= r_out_run ? core_dout : '0;
            out_bin   <= r_out_run ? r_out_cnt : '0;
            out_sof   <= r_out_run && (r_out_cnt == '0);
            out_eof   <= r_out_run && (r_out_cnt == c_LAST);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_ctrl
// Description : Self-checking bench for fft_frame_ctrl. The FFT core is stood
//               in for by a fixed-latency delay line with an XOR signature so
//               that out_data is traceable back to the input samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;

    localparam int N   = 16;
    localparam int DW  = 34;
    localparam int LAT = 19;
    localparam int AW  = 4;
    localparam logic [DW-1:0] MASK = 34'h1_5A5A_A5A5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [DW-1:0] core_din;
    logic [DW-1:0] core_dout;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_bin;
    logic          out_sof;
    logic          out_eof;
    logic          frame_err;
    logic          busy;

    fft_frame_ctrl #(.N(N), .DW(DW), .CORE_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .core_din  (core_din),
        .core_dout (core_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_bin   (out_bin),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Core stand-in: value driven on core_din in cycle T shows on core_dout in T+LAT
    logic [DW-1:0] dly [LAT];
    always @(posedge clk) begin
        dly[0] <= core_din;
        for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
    assign core_dout = dly[LAT-1] ^ MASK;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] bin;
        logic          sof;
        logic          eof;
    } exp_t;

    typedef struct {
        int len;
        int last_idx;
        int base;
        int exp_err;
        int exp_frames;
    } vec_t;

    exp_t          q[$];
    logic [DW-1:0] fbuf [N];
    int            mcnt = 0;
    int            n_vec = 0;
    int            n_fail = 0;
    int            err_cycles = 0;
    int            sof_count = 0;
    int            run_len = 0;
    int            max_run = 0;
    int            first_valid_cyc = -1;
    int            last_acc_cyc = 0;
    bit            saw_stall = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int v);
        return {1'b0, v[15:0], 1'b0, 16'h0000};
    endfunction

    // Scoreboard sink: every tagged output must match the next expected bin
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_err) err_cycles++;
            if (in_valid && !in_ready) saw_stall = 1;
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_sof) sof_count++;
                n_vec++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: out_valid=1 bin=%0d data=%0h, none expected", out_bin, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.data || out_bin !== e.bin || out_sof !== e.sof || out_eof !== e.eof) begin
                        n_fail++;
                        $display("FAIL out_bin_%0d: got data=%0h bin=%0d sof=%0b eof=%0b expected data=%0h bin=%0d sof=%0b eof=%0b",
                                 e.bin, out_data, out_bin, out_sof, out_eof, e.data, e.bin, e.sof, e.eof);
                    end
                end
            end else begin
                run_len = 0;
            end
        end
    end

    // Drive one sample; called and returns at posedge+1. Updates the frame model.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        last_acc_cyc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        fbuf[mcnt] = d;
        if (l && mcnt == N-1) begin
            for (int k = 0; k < N; k++)
                q.push_back('{data: fbuf[k] ^ MASK, bin: AW'(k), sof: (k == 0), eof: (k == N-1)});
            mcnt = 0;
        end else if (l || mcnt == N-1) begin
            mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || busy || out_valid) && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_done", 64'(q.size() != 0 || busy || out_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {in_ready, out_valid, out_sof, out_eof, frame_err, busy, out_bin, core_din, out_data},
              64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        repeat (3) @(posedge clk);
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_clk", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("ready_after_first_clk", 64'(in_ready), 64'd1);
    endtask

    vec_t tbl [4];

    initial begin
        int e0, s0;

        tbl[0] = '{len: 10, last_idx: 9,  base: 'h100, exp_err: 1, exp_frames: 0}; // short frame
        tbl[1] = '{len: 16, last_idx: 15, base: 'h200, exp_err: 0, exp_frames: 1}; // good frame
        tbl[2] = '{len: 17, last_idx: -1, base: 'h300, exp_err: 1, exp_frames: 0}; // long; 17th opens next frame
        tbl[3] = '{len: 15, last_idx: 14, base: 'h400, exp_err: 0, exp_frames: 1}; // completes that frame

        // Reset then idle
        #2;
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        check("idle_core_din", 64'(core_din), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_sof_count", 64'(sof_count), 64'd0);

        // Single frame: core drive cadence and tag latency
        first_valid_cyc = -1;
        for (int k = 0; k < N; k++) send(mk(k), k == N-1);
        check("busy_after_frame", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("core_din_entry_gap", 64'(core_din), 64'd0);
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            check($sformatf("core_din_%0d", k), 64'(core_din), 64'(mk(k)));
        end
        @(posedge clk); #1;
        check("core_din_after_issue", 64'(core_din), 64'd0);
        drain();
        check("tag_latency", 64'(first_valid_cyc - last_acc_cyc), 64'(2 + LAT + 1));
        check("single_frame_count", 64'(sof_count), 64'd1);

        // Three frames back to back
        saw_stall = 0;
        max_run = 0;
        s0 = sof_count;
        for (int k = 0; k < 3*N; k++) send(mk('h40 + k), (k % N) == N-1);
        drain();
        check("both_banks_full_stall", 64'(saw_stall), 64'd1);
        check("back_to_back_run", 64'(max_run >= 2*N), 64'd1);
        check("three_frames_count", 64'(sof_count - s0), 64'd3);

        // Table-driven malformed / recovery frames
        for (int r = 0; r < 4; r++) begin
            e0 = err_cycles;
            s0 = sof_count;
            for (int k = 0; k < tbl[r].len; k++) send(mk(tbl[r].base + k), k == tbl[r].last_idx);
            if (tbl[r].exp_frames > 0) drain();
            else begin
                repeat (5) @(posedge clk);
                #1;
            end
            check($sformatf("row%0d_frame_err", r), 64'(err_cycles - e0), 64'(tbl[r].exp_err));
            check($sformatf("row%0d_frames", r), 64'(sof_count - s0), 64'(tbl[r].exp_frames));
        end

        // Reset while issuing at rd_cnt == 7
        for (int k = 0; k < N; k++) send(mk('h500 + k), k == N-1);
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_core_din", 64'(core_din), 64'(mk('h500 + 6)));
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_issue_reset");
        s0 = sof_count;
        repeat (3) @(posedge clk);
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("post_reset_silent", 64'(sof_count - s0), 64'd0);
        check("post_reset_busy", 64'(busy), 64'd0);
        for (int k = 0; k < N; k++) send(mk('h600 + k), k == N-1);
        drain();
        check("post_reset_new_frame", 64'(sof_count - s0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
